// File: rtl/face_detect_div_pkg.sv
// rtl/face_detect_div_pkg.sv - shared types and default widths for the face_detect sequential divider
package face_detect_div_pkg;

  localparam int DIVIDEND_W_DEF = 21;
  localparam int DIVISOR_W_DEF  = 6;
  localparam int QUOT_W_DEF     = 16;

  // Quotient reported for divide-by-zero and for results too large to represent
  localparam logic [QUOT_W_DEF-1:0] SAT_QUOT = {QUOT_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/face_detect_udiv_21ns_6ns_16_seq.sv
// rtl/face_detect_udiv_21ns_6ns_16_seq.sv - iterative restoring unsigned divider, one quotient bit per cycle
module face_detect_udiv_21ns_6ns_16_seq
  import face_detect_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int QUOT_W     = QUOT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = (QUOT_W > 1) ? $clog2(QUOT_W) : 1;
  localparam int CMP_W = QUOT_W + DIVISOR_W + 1;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [DIVISOR_W-1:0] rem_q;
  logic [QUOT_W-1:0]    quot_q;
  logic [DIVISOR_W-1:0] divisor_q;

  logic                 in_fire;
  logic                 div_zero_in;
  logic                 ovf_in;
  logic [DIVISOR_W-1:0] rem_init;
  logic [QUOT_W-1:0]    quot_init;
  logic [DIVISOR_W:0]   trial;
  logic                 trial_ge;
  logic [DIVISOR_W-1:0] rem_next;
  logic [QUOT_W-1:0]    quot_next;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign in_fire   = in_valid && in_ready && ce;

  // Upper dividend bits seed the partial remainder; they are < divisor whenever no overflow
  assign div_zero_in = (divisor == '0);
  assign ovf_in      = CMP_W'(dividend) >= {1'b0, divisor, {QUOT_W{1'b0}}};
  assign rem_init    = DIVISOR_W'(dividend >> QUOT_W);
  assign quot_init   = dividend[QUOT_W-1:0];

  assign trial     = {rem_q, quot_q[QUOT_W-1]};
  assign trial_ge  = trial >= {1'b0, divisor_q};
  assign rem_next  = trial_ge ? (trial[DIVISOR_W-1:0] - divisor_q) : trial[DIVISOR_W-1:0];
  assign quot_next = {quot_q[QUOT_W-2:0], trial_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE, DONE: begin
          if (in_fire) begin
            divisor_q <= divisor;
            count     <= CNT_W'(QUOT_W - 1);
            if (div_zero_in || ovf_in) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= div_zero_in;
              overflow    <= !div_zero_in;
            end else begin
              state  <= CALC;
              rem_q  <= rem_init;
              quot_q <= quot_init;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          if (count == '0) begin
            state       <= DONE;
            quotient    <= quot_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_face_detect_udiv_21ns_6ns_16_seq.sv
// tb/tb_face_detect_udiv_21ns_6ns_16_seq.sv - directed self-checking bench for the sequential divider
module tb_face_detect_udiv_21ns_6ns_16_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] dividend = '0;
  logic [5:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  face_detect_udiv_21ns_6ns_16_seq dut (
    .clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Present operands and hold them until accepted; returns just after the accepting edge
  task automatic start_op(input logic [20:0] dd, input logic [5:0] dv);
    bit ok;
    ok = 0;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready && ce) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_op: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts active edges until out_valid rises; -1 if it never does
  task automatic wait_result(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (quotient !== 16'd0) begin errors++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %0b want 0", div_by_zero); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    start_op(21'd186, 6'd6);
    // Operand changes after accept must not disturb the running division
    dividend = 21'h1ABCDE;
    divisor  = 6'd0;
    wait_result(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL basic_latency: got %0d want 16", lat); end
    checks++; if (quotient !== 16'd31) begin errors++; $display("FAIL basic_quotient: got %0d want 31", quotient); end
    checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL basic_remainder: got %0d want 0", remainder); end
    checks++; if ({div_by_zero, overflow} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b want 00", {div_by_zero, overflow}); end
    release_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release: out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_max_operands();
    int lat;
    start_op(21'h1FFFFF, 6'd63);
    wait_result(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL max_latency: got %0d want 16", lat); end
    checks++; if (quotient !== 16'd33288) begin errors++; $display("FAIL max_quotient: got %0d want 33288", quotient); end
    checks++; if (remainder !== 6'd7) begin errors++; $display("FAIL max_remainder: got %0d want 7", remainder); end
    release_result();
  endtask

  task automatic test_div_by_zero();
    int lat;
    start_op(21'd100, 6'd0);
    wait_result(0, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL dbz_latency: got %0d want 0", lat); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %0b want 1", div_by_zero); end
    checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dbz_quotient: got %h want ffff", quotient); end
    checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL dbz_remainder: got %0d want 0", remainder); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dbz_ovf: got %0b want 0", overflow); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(21'h10000, 6'd1);
    wait_result(0, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL ovf_latency: got %0d want 0", lat); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL ovf_quotient: got %h want ffff", quotient); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz: got %0b want 0", div_by_zero); end
    release_result();
    start_op(21'hFFFF, 6'd1);
    wait_result(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL edge_latency: got %0d want 16", lat); end
    checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL edge_quotient: got %h want ffff", quotient); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL edge_ovf: got %0b want 0", overflow); end
    checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL edge_remainder: got %0d want 0", remainder); end
    release_result();
  endtask

  task automatic test_round_trip();
    int lat;
    int a;
    int b;
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(32767, 1));
      b = int'($urandom_range(63, 1));
      start_op(21'(a * b), 6'(b));
      wait_result(0, lat);
      checks++; if (quotient !== 16'(a)) begin errors++; $display("FAIL round_trip_q: %0d*%0d got %0d want %0d", a, b, quotient, a); end
      checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL round_trip_r: %0d*%0d got %0d want 0", a, b, remainder); end
      release_result();
    end
  endtask

  task automatic test_stall();
    int lat;
    start_op(21'd777, 6'd5);
    wait_result(0, lat);
    dividend = 21'd12;
    divisor  = 6'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, out_valid); end
      checks++; if (quotient !== 16'd155 || remainder !== 6'd2) begin errors++; $display("FAIL stall_result[%0d]: got %0d r%0d want 155 r2", i, quotient, remainder); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    dividend  = 21'd1000;
    divisor   = 6'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    dividend = 21'd1000;
    divisor  = 6'd9;
    wait_result(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL b2b_first_latency: got %0d want 16", lat); end
    checks++; if (quotient !== 16'd142 || remainder !== 6'd6) begin errors++; $display("FAIL b2b_first: got %0d r%0d want 142 r6", quotient, remainder); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_bubble: out_valid %0b want 0", out_valid); end
    wait_result(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL b2b_second_latency: got %0d want 16", lat); end
    checks++; if (quotient !== 16'd111 || remainder !== 6'd1) begin errors++; $display("FAIL b2b_second: got %0d r%0d want 111 r1", quotient, remainder); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release: out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_ce_stall();
    int lat;
    start_op(21'd500, 6'd3);
    repeat (5) @(posedge clk);
    #1;
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ce_frozen_valid: got %0b want 0", out_valid); end
    ce = 1'b1;
    wait_result(8, lat);
    checks++; if (lat != 19) begin errors++; $display("FAIL ce_latency: got %0d want 19", lat); end
    checks++; if (quotient !== 16'd166 || remainder !== 6'd2) begin errors++; $display("FAIL ce_result: got %0d r%0d want 166 r2", quotient, remainder); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(21'd186, 6'd6);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b want 0", out_valid); end
    checks++; if (quotient !== 16'd0 || remainder !== 6'd0) begin errors++; $display("FAIL midreset_result: got %0d r%0d want 0 r0", quotient, remainder); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %0b want 1", in_ready); end
    start_op(21'd1000, 6'd7);
    wait_result(0, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL midreset_latency: got %0d want 16", lat); end
    checks++; if (quotient !== 16'd142 || remainder !== 6'd6) begin errors++; $display("FAIL midreset_next: got %0d r%0d want 142 r6", quotient, remainder); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_div_by_zero();
    test_overflow();
    test_round_trip();
    test_stall();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
